// File: rtl/psum_pkg.sv
// Shared constants and types for the systolic-array psum collection path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psum_pkg;

    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 64;

    // One signed partial sum as produced by a MAC column.
    typedef logic signed [PSUM_BW-1:0] psum_t;

endpackage : psum_pkg

// File: rtl/psum_lane_fifo.sv
// One column's psum queue; storage read first-word-fall-through.
// Latency: write visible at the head the cycle after the write edge; read is combinational.
// Backpressure: full flag exported; a write to a full lane without a pop is dropped and sets a sticky ovf.
module psum_lane_fifo #(
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [psum_bw-1:0] in,
    input  logic               rd,
    output logic [psum_bw-1:0] out,
    output logic               empty,
    output logic               full,
    output logic               ovf
);

    localparam int addr_w = $clog2(depth);
    localparam logic [addr_w:0] PTR_ONE = {{addr_w{1'b0}}, 1'b1};

    logic [addr_w:0]    wr_ptr_q, wr_ptr_d;
    logic [addr_w:0]    rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic [psum_bw-1:0] mem_q [depth];
    logic               pop;
    logic               wr_acc;

    // Extra pointer MSB distinguishes a full queue from an empty one.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[addr_w-1:0] == rd_ptr_q[addr_w-1:0]) &&
                    (wr_ptr_q[addr_w] != rd_ptr_q[addr_w]);
    assign pop    = rd && !empty;
    // A pop in the same cycle frees the slot, so a write to a full lane still lands.
    assign wr_acc = wr && (!full || pop);
    assign out    = mem_q[rd_ptr_q[addr_w-1:0]];
    assign ovf    = ovf_q;

    // Next-state pointers and sticky overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Pointer and flag state; storage itself is left untouched by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write at the tail index.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[addr_w-1:0]] <= in;
        end
    end

endmodule : psum_lane_fifo

// File: rtl/psum_collector.sv
// South-edge psum collector: per-column lane queues de-skew array output into whole rows (ReLU on read when PSUM_COLLECTOR_RELU_EN is defined).
// Latency: a row is valid the cycle after its last lane is written; head row read is combinational (FWFT).
// Backpressure: o_ready drops while any lane is full; rd without o_valid is ignored.
module psum_collector
    import psum_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in_s,
    input  logic [col-1:0]         wr_valid,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic [col-1:0]         ovf
);

    logic [col-1:0] lane_empty;
    logic [col-1:0] lane_full;
    logic           pop;

    // A row exists only once every column has delivered its word.
    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign pop     = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        logic [psum_bw-1:0] head;

        psum_lane_fifo #(
            .psum_bw(psum_bw),
            .depth  (depth)
        ) u_fifo (
            .clk  (clk),
            .reset(reset),
            .wr   (wr_valid[i]),
            .in   (in_s[psum_bw*i +: psum_bw]),
            .rd   (pop),
            .out  (head),
            .empty(lane_empty[i]),
            .full (lane_full[i]),
            .ovf  (ovf[i])
        );

`ifdef PSUM_COLLECTOR_RELU_EN
        // Clamp negative psums to zero on the way out; queued data stays raw.
        assign out[psum_bw*i +: psum_bw] = head[psum_bw-1] ? '0 : head;
`else
        assign out[psum_bw*i +: psum_bw] = head;
`endif
    end

endmodule : psum_collector
